// File: rtl/lap_timer_pkg.sv
// Shared types and default parameters for the lap timer.
// Holds the FSM state encoding used by the top and exposed on the debug port.
package lap_timer_pkg;

  localparam int DEF_CLK_PER_TICK = 100000;
  localparam int DEF_CNT_W        = 10;
  localparam int DEF_LAPS         = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/lap_timer_if.sv
// Control and status bundle of the lap timer.
// start/abort/btn are level inputs with no handshake; ready is high only while the timer sits in IDLE.
interface lap_timer_if
  import lap_timer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int LAPS  = DEF_LAPS
);
  localparam int SEL_W = (LAPS > 1) ? $clog2(LAPS) : 1;
  localparam int LC_W  = $clog2(LAPS + 1);

  logic             start;
  logic             abort;
  logic             btn;
  logic [SEL_W-1:0] lap_sel;
  logic             ready;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] elapsed;
  logic [LC_W-1:0]  lap_count;
  logic [CNT_W-1:0] lap_ms;

  modport master (
    output start, abort, btn, lap_sel,
    input  ready, done, timeout, elapsed, lap_count, lap_ms
  );

  modport slave (
    input  start, abort, btn, lap_sel,
    output ready, done, timeout, elapsed, lap_count, lap_ms
  );
endinterface

// File: rtl/lap_timer_tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_PER_TICK enabled clocks.
// tick is combinational so the caller sees it in the same cycle the counter wraps.
module tick_gen
  import lap_timer_pkg::*;
#(
  parameter int CLK_PER_TICK = DEF_CLK_PER_TICK
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(CLK_PER_TICK);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == W'(CLK_PER_TICK - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/lap_timer.sv
// Millisecond lap timer: armed by start, run and laps driven by a synchronised pushbutton.
// Saturates at the top of the elapsed count and flags timeout instead of wrapping.
module lap_timer
  import lap_timer_pkg::*;
#(
  parameter int CLK_PER_TICK = DEF_CLK_PER_TICK,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int LAPS         = DEF_LAPS
) (
  input  logic        clk,
  input  logic        rst,
  lap_timer_if.slave  bus,
  output state_t      state_dbg
);
  localparam int LC_W = $clog2(LAPS + 1);

  state_t           state;
  logic             sync1, sync2, sync3;
  logic             btn_edge;
  logic             tick;
  logic             ready, done, timeout;
  logic [CNT_W-1:0] elapsed;
  logic [LC_W-1:0]  lap_count;
  logic [CNT_W-1:0] lap_q [LAPS];
  logic             last_lap;
  logic             sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= bus.btn;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign btn_edge = sync2 & ~sync3;
  assign last_lap = (lap_count == LC_W'(LAPS - 1));
  assign sat      = (elapsed == '1);

  tick_gen #(.CLK_PER_TICK(CLK_PER_TICK)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  ((state == ST_ARM) && btn_edge),
    .en   (state == ST_RUN),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      timeout   <= 1'b0;
      elapsed   <= '0;
      lap_count <= '0;
      for (int i = 0; i < LAPS; i++) lap_q[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state     <= ST_ARM;
            ready     <= 1'b0;
            timeout   <= 1'b0;
            lap_count <= '0;
            elapsed   <= '0;
          end
        end
        ST_ARM: begin
          if (bus.abort) begin
            state <= ST_IDLE;
            ready <= 1'b1;
          end else if (btn_edge) begin
            state   <= ST_RUN;
            elapsed <= '0;
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            state <= ST_IDLE;
            ready <= 1'b1;
          end else begin
            // Capture uses the pre-increment elapsed even when a tick lands in the same cycle.
            if (btn_edge) begin
              lap_q[lap_count] <= elapsed;
              lap_count        <= lap_count + 1'b1;
            end
            if (btn_edge && last_lap) begin
              state <= ST_DONE;
              done  <= 1'b1;
              if (tick && sat) timeout <= 1'b1;
            end else if (tick) begin
              if (sat) begin
                timeout <= 1'b1;
                state   <= ST_DONE;
                done    <= 1'b1;
              end else begin
                elapsed <= elapsed + 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    bus.lap_ms = '0;
    if (32'(bus.lap_sel) < 32'(lap_count)) bus.lap_ms = lap_q[bus.lap_sel];
  end

  assign bus.ready     = ready;
  assign bus.done      = done;
  assign bus.timeout   = timeout;
  assign bus.elapsed   = elapsed;
  assign bus.lap_count = lap_count;
  assign state_dbg     = state;
endmodule

// File: tb/tb_lap_timer.sv
// Directed bench for lap_timer with CLK_PER_TICK=4, CNT_W=4, LAPS=3.
// Inputs change and outputs are sampled on the falling edge.
module tb_lap_timer;
  import lap_timer_pkg::*;

  localparam int CPT = 4;
  localparam int CW  = 4;
  localparam int NL  = 3;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t state_dbg;

  lap_timer_if #(.CNT_W(CW), .LAPS(NL)) bus ();

  lap_timer #(.CLK_PER_TICK(CPT), .CNT_W(CW), .LAPS(NL)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int assert_cnt = 0;
  int fail_cnt   = 0;
  int done_cnt   = 0;
  logic [CW-1:0] exp_q[$];

  always @(posedge clk) begin
    if (!rst && bus.done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // drivers
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling edge; the synchronised edge acts on the third rising edge after.
  task automatic press();
    bus.btn = 1'b1;
    @(negedge clk);
    bus.btn = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic do_abort();
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
  endtask

  task automatic check_laps(input int n);
    logic [CW-1:0] e;
    for (int i = 0; i < NL; i++) begin
      bus.lap_sel = i[1:0];
      #1;
      e = (i < n) ? exp_q.pop_front() : '0;
      check($sformatf("lap_ms[%0d]", i), bus.lap_ms, e);
    end
    bus.lap_sel = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ready"},     bus.ready,     1);
    check({tag, " done"},      bus.done,      0);
    check({tag, " elapsed"},   bus.elapsed,   0);
    check({tag, " lap_count"}, bus.lap_count, 0);
    check({tag, " timeout"},   bus.timeout,   0);
    check({tag, " state"},     32'(state_dbg), 32'(ST_IDLE));
  endtask

  int dc;
  int n;

  initial begin
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.btn     = 1'b0;
    bus.lap_sel = '0;
    rst         = 1'b1;
    cycles(2);
    rst = 1'b0;

    // reset values
    check_reset_outputs("reset");

    // three laps at 3, 5 and 9 ticks
    do_start();
    check("arm ready", bus.ready, 0);
    press();
    check("run elapsed start", bus.elapsed, 0);
    dc = done_cnt;
    cycles(10);
    press();
    check("lap1 count", bus.lap_count, 1);
    cycles(5);
    press();
    check("lap2 count", bus.lap_count, 2);
    cycles(13);
    press();
    check("laps done", bus.done, 1);
    check("laps elapsed", bus.elapsed, 9);
    check("laps lap_count", bus.lap_count, 3);
    cycles(1);
    check("laps done low", bus.done, 0);
    check("laps ready", bus.ready, 1);
    cycles(2);
    check("laps done pulses", done_cnt - dc, 1);
    check("laps elapsed held", bus.elapsed, 9);
    exp_q.push_back(4'd3);
    exp_q.push_back(4'd5);
    exp_q.push_back(4'd9);
    check_laps(3);

    // no laps: saturate and time out
    do_start();
    press();
    dc = done_cnt;
    n = 0;
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("sat cycles to done", n, 64);
    check("sat elapsed", bus.elapsed, 15);
    check("sat timeout", bus.timeout, 1);
    check("sat lap_count", bus.lap_count, 0);
    cycles(2);
    check("sat done pulses", done_cnt - dc, 1);
    check("sat ready", bus.ready, 1);
    check("sat elapsed held", bus.elapsed, 15);
    check("sat timeout held", bus.timeout, 1);

    // edge coincides with tick at elapsed=6, second lap, then abort
    do_start();
    check("restart timeout cleared", bus.timeout, 0);
    check("restart elapsed cleared", bus.elapsed, 0);
    press();
    dc = done_cnt;
    cycles(25);
    press();
    check("coincide elapsed", bus.elapsed, 7);
    check("coincide lap_count", bus.lap_count, 1);
    cycles(2);
    press();
    check("second lap elapsed", bus.elapsed, 8);
    do_abort();
    check("abort ready", bus.ready, 1);
    check("abort lap_count", bus.lap_count, 2);
    check("abort done", bus.done, 0);
    cycles(2);
    check("abort no done pulse", done_cnt - dc, 0);
    exp_q.push_back(4'd6);
    exp_q.push_back(4'd8);
    check_laps(2);
    press();
    check("idle edge lap_count", bus.lap_count, 2);
    check("idle edge ready", bus.ready, 1);
    check("idle edge elapsed", bus.elapsed, 8);

    // reset in the middle of a run
    do_start();
    press();
    dc = done_cnt;
    cycles(14);
    press();
    check("pre-reset elapsed", bus.elapsed, 4);
    check("pre-reset lap_count", bus.lap_count, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("mid-run reset");
    check("mid-run reset lap_ms", bus.lap_ms, 0);
    do_start();
    press();
    check("post-reset elapsed 0", bus.elapsed, 0);
    cycles(4);
    check("post-reset elapsed 1", bus.elapsed, 1);
    check("post-reset no done", done_cnt - dc, 0);
    do_abort();
    check("post-reset abort ready", bus.ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end
endmodule

// File: doc/lap_timer.md
LAP_TIMER -- requirements
Module: lap_timer

Interface
REQ-001 The block SHALL have parameter CLK_PER_TICK, default 100000, clocks per 1 ms tick (>=2).
REQ-002 The block SHALL have parameter CNT_W, default 10, elapsed-count width in ticks.
REQ-003 The block SHALL have parameter LAPS, default 4, number of lap registers (>=1).
REQ-004 The block SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-006 The block SHALL have port start  input  1  arm request, level-sampled in IDLE only.
REQ-007 The block SHALL have port abort  input  1  cancel the run, honoured in ARM and RUN.
REQ-008 The block SHALL have port btn  input  1  asynchronous pushbutton.
REQ-009 The block SHALL have port lap_sel  input  clog2(LAPS) (min 1)  lap read index.
REQ-010 The block SHALL have port ready  output  1  high only in IDLE.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse on run completion.
REQ-012 The block SHALL have port timeout  output  1  sticky flag: last run saturated.
REQ-013 The block SHALL have port elapsed  output  CNT_W  current or final tick count.
REQ-014 The block SHALL have port lap_count  output  clog2(LAPS+1)  number of laps captured.
REQ-015 The block SHALL have port lap_ms  output  CNT_W  lap[lap_sel]; 0 if lap_sel >= lap_count.

Function
REQ-016 btn SHALL pass through a 2-flop synchronizer; edge = sync2 & ~sync3; the FSM acts on edge in the same cycle.
REQ-017 The FSM SHALL have states IDLE, ARM, RUN, DONE; illegal encodings SHALL go to IDLE.
REQ-018 In IDLE, start=1 SHALL go to ARM; it SHALL clear timeout, lap_count and elapsed.
REQ-019 In ARM, edge SHALL go to RUN and zero the tick prescaler and elapsed.
REQ-020 In RUN, the prescaler SHALL count 0..CLK_PER_TICK-1 and wrap; at wrap, elapsed SHALL increment by 1.
REQ-021 In RUN, edge SHALL write the current elapsed (pre-increment) into lap[lap_count] and increment lap_count.
REQ-022 An edge that fills the last lap (lap_count reaches LAPS) SHALL go to DONE; elapsed SHALL freeze.
REQ-023 If elapsed = 2^CNT_W-1 and a tick occurs, elapsed SHALL NOT wrap; timeout SHALL set and the FSM SHALL go to DONE.
REQ-024 If edge and tick coincide, the lap capture SHALL take precedence: the pre-increment value is stored, and the increment is still applied unless the edge completes the run.
REQ-025 If edge and saturation coincide, the lap SHALL be captured, timeout SHALL set, and the FSM SHALL go to DONE.
REQ-026 DONE SHALL assert done for exactly one cycle, then go to IDLE; elapsed, laps and timeout SHALL hold until the next start.
REQ-027 abort in ARM or RUN SHALL go to IDLE the next cycle without a done pulse; captured laps SHALL remain readable. abort SHALL have priority over edge and tick.
REQ-028 start SHALL be ignored outside IDLE; edges SHALL be ignored in IDLE and DONE.
REQ-029 lap_ms SHALL be combinational from the lap registers and lap_sel.

Reset
REQ-030 rst=1 SHALL, at the next clk edge, force IDLE, clear the prescaler, elapsed, lap_count, all laps, timeout, done and the sync flops; ready SHALL be 1 in the first cycle after reset.
REQ-031 rst asserted mid-RUN SHALL abandon the run with no done pulse.

Structure
REQ-032 Package lap_timer_pkg SHALL hold the state enum typedef and the default parameter constants.
REQ-033 The prescaler SHALL be a sub-module tick_gen (params CLK_PER_TICK; ports clk, rst, clr, en, tick).

Verification (CLK_PER_TICK=4, CNT_W=4, LAPS=3)
REQ-034 The bench SHALL check: reset -> ready=1, done=0, elapsed=0, lap_count=0, timeout=0.
REQ-035 The bench SHALL check: start, btn edge, then edges after 3, 5 and 9 ticks -> laps 3,5,9; lap_count=3; a single done pulse; elapsed=9.
REQ-036 The bench SHALL check: start, edge, no further edges -> elapsed stops at 15, timeout=1, done pulses once, lap_count=0.
REQ-037 The bench SHALL check: edge placed in the cycle of a tick with elapsed=6 -> lap=6 and elapsed becomes 7.
REQ-038 The bench SHALL check: abort after 2 laps -> IDLE, no done, lap_count=2, lap_sel=2 reads 0.
REQ-039 The bench SHALL check: rst mid-RUN at elapsed=4 -> all outputs at reset values next cycle; start+edge restarts from 0.
